// File: rtl/sobel_window_if.sv
// Beat bus between the row shift stage, the Sobel window stage and the edge writeback stage.
// The slave side accepts row beats and produces edge magnitudes.
interface sobel_window_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [31:0] row_top;
  logic [31:0] row_mid;
  logic [31:0] row_bot;
  logic        out_valid;
  logic [31:0] edge_out;

  modport master (
    output in_valid, in_last, row_top, row_mid, row_bot,
    input  in_ready, out_valid, edge_out
  );

  modport slave (
    input  in_valid, in_last, row_top, row_mid, row_bot,
    output in_ready, out_valid, edge_out
  );
endinterface

// File: rtl/sobel_window.sv
// Sobel |Gx|+|Gy| stage: holds one word of horizontal context per row, builds 3x3
// windows across word boundaries (zero padded at line ends) and emits four saturated magnitudes.
module sobel_window (
  input  logic            clk,
  input  logic            rst_n,
  sobel_window_if.slave   bus
);

  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_FLUSH} state_t;

  state_t             r_state;
  logic [31:0]        r_cur_top, r_cur_mid, r_cur_bot;
  logic [7:0]         r_lctx_top, r_lctx_mid, r_lctx_bot;
  logic [47:0]        r_win_top_p0, r_win_mid_p0, r_win_bot_p0;
  logic               r_vld_p0;
  logic signed [10:0] r_gx_p1 [4];
  logic signed [10:0] r_gy_p1 [4];
  logic               r_vld_p1;
  logic [31:0]        r_edge_p2;
  logic               r_vld_p2;
  logic               w_accept;

  function automatic logic signed [10:0] ext11(input logic [7:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic signed [10:0] calc_gx(input logic [7:0] a, c, d, f, g, i);
    return (ext11(c) - ext11(a)) + ((ext11(f) - ext11(d)) <<< 1) + (ext11(i) - ext11(g));
  endfunction

  function automatic logic signed [10:0] calc_gy(input logic [7:0] a, b, c, g, h, i);
    return (ext11(g) + (ext11(h) <<< 1) + ext11(i)) - (ext11(a) + (ext11(b) <<< 1) + ext11(c));
  endfunction

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    return v[10] ? 11'(-v) : 11'(v);
  endfunction

  function automatic logic [7:0] sat8(input logic signed [10:0] gx, input logic signed [10:0] gy);
    logic [11:0] mag;
    mag = {1'b0, abs11(gx)} + {1'b0, abs11(gy)};
    return (mag > 12'd255) ? 8'hFF : mag[7:0];
  endfunction

  assign bus.in_ready  = (r_state != S_FLUSH);
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = r_vld_p2;
  assign bus.edge_out  = r_edge_p2;

  // Control FSM and window capture (stage p0); window byte 0 = left context, byte 5 = right
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_cur_top    <= '0;
      r_cur_mid    <= '0;
      r_cur_bot    <= '0;
      r_lctx_top   <= '0;
      r_lctx_mid   <= '0;
      r_lctx_bot   <= '0;
      r_win_top_p0 <= '0;
      r_win_mid_p0 <= '0;
      r_win_bot_p0 <= '0;
      r_vld_p0     <= 1'b0;
    end else begin
      r_vld_p0 <= 1'b0;
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_cur_top  <= bus.row_top;
            r_cur_mid  <= bus.row_mid;
            r_cur_bot  <= bus.row_bot;
            r_lctx_top <= '0;
            r_lctx_mid <= '0;
            r_lctx_bot <= '0;
            r_state    <= bus.in_last ? S_FLUSH : S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_accept) begin
            r_win_top_p0 <= {bus.row_top[7:0], r_cur_top, r_lctx_top};
            r_win_mid_p0 <= {bus.row_mid[7:0], r_cur_mid, r_lctx_mid};
            r_win_bot_p0 <= {bus.row_bot[7:0], r_cur_bot, r_lctx_bot};
            r_vld_p0     <= 1'b1;
            r_lctx_top   <= r_cur_top[31:24];
            r_lctx_mid   <= r_cur_mid[31:24];
            r_lctx_bot   <= r_cur_bot[31:24];
            r_cur_top    <= bus.row_top;
            r_cur_mid    <= bus.row_mid;
            r_cur_bot    <= bus.row_bot;
            r_state      <= bus.in_last ? S_FLUSH : S_HOLD;
          end
        end
        S_FLUSH: begin
          r_win_top_p0 <= {8'h00, r_cur_top, r_lctx_top};
          r_win_mid_p0 <= {8'h00, r_cur_mid, r_lctx_mid};
          r_win_bot_p0 <= {8'h00, r_cur_bot, r_lctx_bot};
          r_vld_p0     <= 1'b1;
          r_lctx_top   <= '0;
          r_lctx_mid   <= '0;
          r_lctx_bot   <= '0;
          r_state      <= S_EMPTY;
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  // Stage p1: gradients; stage p2: saturated magnitudes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_gx_p1[k] <= '0;
        r_gy_p1[k] <= '0;
      end
      r_vld_p1  <= 1'b0;
      r_edge_p2 <= '0;
      r_vld_p2  <= 1'b0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p0) begin
        for (int k = 0; k < 4; k++) begin
          r_gx_p1[k] <= calc_gx(r_win_top_p0[8*k +: 8], r_win_top_p0[8*(k+2) +: 8],
                                r_win_mid_p0[8*k +: 8], r_win_mid_p0[8*(k+2) +: 8],
                                r_win_bot_p0[8*k +: 8], r_win_bot_p0[8*(k+2) +: 8]);
          r_gy_p1[k] <= calc_gy(r_win_top_p0[8*k +: 8], r_win_top_p0[8*(k+1) +: 8],
                                r_win_top_p0[8*(k+2) +: 8],
                                r_win_bot_p0[8*k +: 8], r_win_bot_p0[8*(k+1) +: 8],
                                r_win_bot_p0[8*(k+2) +: 8]);
        end
      end
      if (r_vld_p1) begin
        for (int k = 0; k < 4; k++) begin
          r_edge_p2[8*k +: 8] <= sat8(r_gx_p1[k], r_gy_p1[k]);
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window.sv
// Scoreboard bench for sobel_window: a per-pixel reference model pushes expected words
// when a line is driven; the output monitor pops and compares each pulse.
module tb_sobel_window;

  logic clk;
  logic rst_n;
  sobel_window_if bus ();

  sobel_window dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_tot  = 0;
  int          pulses = 0;
  logic [31:0] sb [$];
  logic [31:0] lt [8];
  logic [31:0] lm [8];
  logic [31:0] lb [8];
  logic        gap_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int px(input int r, input int x, input int n);
    logic [31:0] w;
    if (x < 0 || x >= 4 * n) return 0;
    w = (r == 0) ? lt[x / 4] : (r == 1) ? lm[x / 4] : lb[x / 4];
    return int'(w[8 * (x % 4) +: 8]);
  endfunction

  function automatic logic [31:0] model_word(input int w, input int n);
    logic [31:0] res;
    int x, gx, gy, m;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      x  = 4 * w + k;
      gx = (px(0, x + 1, n) - px(0, x - 1, n)) + 2 * (px(1, x + 1, n) - px(1, x - 1, n))
         + (px(2, x + 1, n) - px(2, x - 1, n));
      gy = (px(2, x - 1, n) + 2 * px(2, x, n) + px(2, x + 1, n))
         - (px(0, x - 1, n) + 2 * px(0, x, n) + px(0, x + 1, n));
      m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      res[8 * k +: 8] = (m > 255) ? 8'hFF : 8'(m);
    end
    return res;
  endfunction

  task automatic fill_random(input int n);
    for (int w = 0; w < n; w++) begin
      lt[w] = $urandom;
      lm[w] = $urandom;
      lb[w] = $urandom;
    end
  endtask

  // Called and returns on a falling edge; returns on the negedge after the last accept.
  task automatic drive_line(input int n, input logic last_flag, input logic push, input logic keep_valid);
    int t;
    if (push) begin
      for (int w = 0; w < n; w++)
        if (w < n - 1 || last_flag) sb.push_back(model_word(w, n));
    end
    for (int w = 0; w < n; w++) begin
      if (gap_en && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.row_top  = lt[w];
      bus.row_mid  = lm[w];
      bus.row_bot  = lb[w];
      bus.in_last  = last_flag && (w == n - 1);
      t = 0;
      while (!bus.in_ready && t < 10) begin
        @(negedge clk);
        t++;
      end
      if (t >= 10) begin
        chk("ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!keep_valid) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ov"},  32'(bus.out_valid), 32'd0);
    chk({tag, "_eo"},  bus.edge_out,       32'h0);
    chk({tag, "_rdy"}, 32'(bus.in_ready),  32'd1);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid) begin
      pulses++;
      if (sb.size() == 0) chk("spurious_pulse", 32'd1, 32'd0);
      else chk("edge_out", bus.edge_out, sb.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.row_top  = '0;
    bus.row_mid  = '0;
    bus.row_bot  = '0;
    rst_n = 1'b0;
    idle(3);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    idle(1);

    // Flat line: two words, bubble and latency checked cycle by cycle
    for (int w = 0; w < 2; w++) begin
      lt[w] = 32'h80808080; lm[w] = 32'h80808080; lb[w] = 32'h80808080;
    end
    sb.push_back(32'h000000FF);
    sb.push_back(32'hFF000000);
    drive_line(2, 1'b1, 1'b0, 1'b0);
    chk("flush_rdy_low", 32'(bus.in_ready), 32'd0);
    chk("flat_ov_n1",    32'(bus.out_valid), 32'd0);
    idle(1);
    chk("flush_rdy_back", 32'(bus.in_ready), 32'd1);
    chk("flat_ov_n2",     32'(bus.out_valid), 32'd0);
    idle(1);
    chk("flat_ov_n3", 32'(bus.out_valid), 32'd1);
    idle(1);
    chk("flat_ov_n4", 32'(bus.out_valid), 32'd1);
    idle(1);
    chk("flat_ov_n5", 32'(bus.out_valid), 32'd0);
    idle(3);
    chk("flat_drain", 32'(sb.size()), 32'd0);

    // Single-word line, both borders zero padded
    lt[0] = 32'h0; lm[0] = 32'h0; lb[0] = 32'h10101010;
    sb.push_back(32'h40404040);
    drive_line(1, 1'b1, 1'b0, 1'b0);
    idle(6);
    chk("single_drain", 32'(sb.size()), 32'd0);

    // Alternating full-scale pattern over four words
    for (int w = 0; w < 4; w++) begin
      lt[w] = 32'hFF00FF00; lm[w] = 32'h00FF00FF; lb[w] = 32'hFF00FF00;
    end
    drive_line(4, 1'b1, 1'b1, 1'b0);
    idle(6);
    chk("sat_drain", 32'(sb.size()), 32'd0);

    // Back-to-back lines with in_valid held high across the bubble
    fill_random(3);
    drive_line(3, 1'b1, 1'b1, 1'b1);
    fill_random(2);
    drive_line(2, 1'b1, 1'b1, 1'b0);
    idle(6);
    chk("b2b_drain", 32'(sb.size()), 32'd0);

    // Random lines with idle gaps inside HOLD
    gap_en = 1'b1;
    for (int l = 0; l < 3; l++) begin
      fill_random(5);
      drive_line(5, 1'b1, 1'b1, 1'b0);
    end
    gap_en = 1'b0;
    idle(6);
    chk("gap_drain", 32'(sb.size()), 32'd0);

    // Reset mid-stream: word 0 emerges, word 1 in flight is discarded
    fill_random(3);
    drive_line(3, 1'b0, 1'b1, 1'b0);
    idle(1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    chk("rst_mid_left", 32'(sb.size()), 32'd1);
    sb.delete();
    p0 = pulses;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    fill_random(1);
    drive_line(1, 1'b0, 1'b0, 1'b0);
    idle(6);
    chk("first_word_silent", 32'(pulses - p0), 32'd0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);

    // Reset during FLUSH: neither the in-flight nor the pending word may pulse
    fill_random(2);
    drive_line(2, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_flush_rdy", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_flush");
    p0 = pulses;
    idle(1);
    rst_n = 1'b1;
    idle(6);
    chk("rst_flush_silent", 32'(pulses - p0), 32'd0);

    // Clean line after reset
    fill_random(2);
    drive_line(2, 1'b1, 1'b1, 1'b0);
    idle(6);
    chk("final_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
